// File: rtl/fifo_drain_reader.sv
// fifo_drain_reader: FIFO read-side consumer that re-presents words on a valid/ready stream
// through a 2-entry buffer. Define FIFO_DRAIN_READER_COUNT_EN to add the RD_COUNT output.
module fifo_drain_reader #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned BUF_DEPTH  = 2
) (
    input  logic                  FCLK,
    input  logic                  FRSTN,
    input  logic                  FIFO_EMPTY,
    output logic                  FIFO_RD_EN,
    input  logic [DATA_WIDTH-1:0] FIFO_DATA,
    input  logic                  FLUSH,
    output logic                  M_VALID,
    input  logic                  M_READY,
    output logic [DATA_WIDTH-1:0] M_DATA,
`ifdef FIFO_DRAIN_READER_COUNT_EN
    output logic [15:0]           RD_COUNT,
`endif
    output logic                  BUSY
);

    if (BUF_DEPTH != 2) begin : g_bad_depth
        $error("fifo_drain_reader: BUF_DEPTH must be 2");
    end

    logic [1:0]            occ_q, occ_d;
    logic                  inflight_q, drop_q, run_q;
    logic [DATA_WIDTH-1:0] head_q, head_d, tail_q, tail_d;
    logic                  pop, cap;
    logic [2:0]            credit;

    always_comb begin
        pop        = M_VALID & M_READY;
        // Words that will sit in the buffer after this edge; a new strobe needs room for one more.
        credit     = 3'(occ_q) + 3'(inflight_q) - 3'(pop);
        FIFO_RD_EN = run_q & ~FIFO_EMPTY & ~FLUSH & (credit <= 3'd1);
        cap        = inflight_q & ~drop_q & ~FLUSH;
    end

    always_comb begin
        occ_d  = occ_q;
        head_d = head_q;
        tail_d = tail_q;
        if (FLUSH) begin
            occ_d = '0;
        end else begin
            unique case ({cap, pop})
                2'b10: begin
                    if (occ_q == 2'd0) head_d = FIFO_DATA;
                    else               tail_d = FIFO_DATA;
                    occ_d = occ_q + 2'd1;
                end
                2'b01: begin
                    if (occ_q == 2'd2) head_d = tail_q;
                    occ_d = occ_q - 2'd1;
                end
                2'b11: begin
                    if (occ_q == 2'd1) begin
                        head_d = FIFO_DATA;
                    end else begin
                        head_d = tail_q;
                        tail_d = FIFO_DATA;
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge FCLK or negedge FRSTN) begin
        if (!FRSTN) begin
            occ_q      <= '0;
            inflight_q <= 1'b0;
            drop_q     <= 1'b0;
            run_q      <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
        end else begin
            occ_q      <= occ_d;
            inflight_q <= FIFO_RD_EN;
            drop_q     <= FLUSH & inflight_q;
            run_q      <= 1'b1;
            head_q     <= head_d;
            tail_q     <= tail_d;
        end
    end

    assign M_VALID = (occ_q != 2'd0);
    assign M_DATA  = head_q;
    assign BUSY    = (occ_q != 2'd0) | inflight_q | drop_q;

`ifdef FIFO_DRAIN_READER_COUNT_EN
    logic [15:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (FLUSH)                  cnt_d = '0;
        else if (pop && cnt_q != '1) cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge FCLK or negedge FRSTN) begin
        if (!FRSTN) cnt_q <= '0;
        else        cnt_q <= cnt_d;
    end

    assign RD_COUNT = cnt_q;
`endif

endmodule

// File: tb/tb_fifo_drain_reader.sv
// Bench for fifo_drain_reader: behavioural FIFO source, scoreboard of expected stream words.
module tb_fifo_drain_reader;
    localparam int unsigned DW = 8;

    logic          FCLK       = 1'b0;
    logic          FRSTN      = 1'b0;
    logic          FIFO_EMPTY = 1'b1;
    logic          FLUSH      = 1'b0;
    logic          M_READY    = 1'b0;
    logic [DW-1:0] FIFO_DATA  = '0;
    logic          FIFO_RD_EN, M_VALID, BUSY;
    logic [DW-1:0] M_DATA;
`ifdef FIFO_DRAIN_READER_COUNT_EN
    logic [15:0]   RD_COUNT;
`endif

    int checks = 0, errors = 0;
    int cyc = 0, strobes = 0, pops = 0, valid_cycles = 0;
    int first_strobe = -1, first_valid = -1;
    int pop_cyc[$];
    logic [DW-1:0] fifo_mem[$];
    logic [DW-1:0] exp_q[$];
    logic          hold_prev = 1'b0;
    logic [DW-1:0] prev_data = '0;

    always #5 FCLK = ~FCLK;

    fifo_drain_reader #(.DATA_WIDTH(DW), .BUF_DEPTH(2)) dut (
        .FCLK       (FCLK),
        .FRSTN      (FRSTN),
        .FIFO_EMPTY (FIFO_EMPTY),
        .FIFO_RD_EN (FIFO_RD_EN),
        .FIFO_DATA  (FIFO_DATA),
        .FLUSH      (FLUSH),
        .M_VALID    (M_VALID),
        .M_READY    (M_READY),
        .M_DATA     (M_DATA),
`ifdef FIFO_DRAIN_READER_COUNT_EN
        .RD_COUNT   (RD_COUNT),
`endif
        .BUSY       (BUSY)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Source FIFO: data one cycle after the strobe, EMPTY registered
    always @(posedge FCLK) begin
        cyc++;
        if (FIFO_RD_EN) begin
            chk("fifo_underflow", 32'(fifo_mem.size() != 0), 32'd1);
            if (fifo_mem.size() != 0) FIFO_DATA <= fifo_mem.pop_front();
        end
        FIFO_EMPTY <= (fifo_mem.size() == 0);
    end

    always @(negedge FCLK) begin
        if (FRSTN) begin
            chk("occ_max", 32'(dut.occ_q <= 2'd2), 32'd1);
            if (FIFO_RD_EN) begin
                strobes++;
                if (first_strobe < 0) first_strobe = cyc;
            end
            if (M_VALID) begin
                valid_cycles++;
                if (first_valid < 0) first_valid = cyc;
            end
            if (hold_prev) begin
                chk("hold_valid", 32'(M_VALID), 32'd1);
                chk("hold_data", 32'(M_DATA), 32'(prev_data));
            end
            if (M_VALID && M_READY) begin
                chk("sb_has_entry", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) chk("sb_data", 32'(M_DATA), 32'(exp_q.pop_front()));
                pops++;
                pop_cyc.push_back(cyc);
            end
            hold_prev = M_VALID && !M_READY && !FLUSH;
            prev_data = M_DATA;
        end else begin
            hold_prev = 1'b0;
        end
    end

    task automatic tick();
        @(posedge FCLK);
        #1;
    endtask

    task automatic push_word(input logic [DW-1:0] w);
        fifo_mem.push_back(w);
        exp_q.push_back(w);
    endtask

    task automatic clear_stats();
        strobes = 0; pops = 0; valid_cycles = 0;
        first_strobe = -1; first_valid = -1;
        pop_cyc.delete();
    endtask

    task automatic wait_pops(input string tag, input int n, input int budget);
        int k = 0;
        while (pops < n && k < budget) begin
            tick();
            k++;
        end
        chk(tag, 32'(pops), 32'(n));
    endtask

    task automatic wait_idle(input string tag, input int budget);
        int k = 0;
        while (BUSY && k < budget) begin
            tick();
            k++;
        end
        chk(tag, 32'(BUSY), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        // Reset with words waiting in the FIFO
        for (int i = 0; i < 4; i++) push_word(8'(17 * (i + 1)));
        tick();
        repeat (2) begin
            @(negedge FCLK);
            chk("rst_rd_en", 32'(FIFO_RD_EN), 32'd0);
            chk("rst_valid", 32'(M_VALID), 32'd0);
            chk("rst_data", 32'(M_DATA), 32'd0);
            chk("rst_busy", 32'(BUSY), 32'd0);
        end
        tick();
        clear_stats();
        M_READY = 1'b1;
        FRSTN   = 1'b1;
        @(negedge FCLK);
        chk("rel_rd_en", 32'(FIFO_RD_EN), 32'd0);

        // Stream 11,22,33,44 at full rate
        wait_pops("stream_pops", 4, 20);
        chk("stream_latency", 32'(first_valid - first_strobe), 32'd2);
        chk("stream_b2b", (pop_cyc.size() == 4) ? 32'(pop_cyc[3] - pop_cyc[0]) : 32'hFFFF_FFFF, 32'd3);
        wait_idle("stream_idle", 10);
        chk("stream_strobes", 32'(strobes), 32'd4);

        // Backpressure
        M_READY = 1'b0;
        clear_stats();
        for (int i = 0; i < 4; i++) push_word(8'(17 * (i + 1)));
        repeat (5) tick();
        chk("bp_strobes", 32'(strobes), 32'd2);
        chk("bp_occ", 32'(dut.occ_q), 32'd2);
        chk("bp_valid", 32'(M_VALID), 32'd1);
        chk("bp_data", 32'(M_DATA), 32'h11);
        M_READY = 1'b1;
        wait_pops("bp_pops", 4, 30);
        wait_idle("bp_idle", 10);
        chk("bp_strobes_total", 32'(strobes), 32'd4);

        // Single word
        clear_stats();
        push_word(8'hA5);
        wait_pops("single_pops", 1, 20);
        wait_idle("single_idle", 10);
        chk("single_strobes", 32'(strobes), 32'd1);
        chk("single_valid_cycles", 32'(valid_cycles), 32'd1);

        // Flush with a full buffer and a concurrent pop
        M_READY = 1'b0;
        clear_stats();
        push_word(8'h61); push_word(8'h62); push_word(8'h63);
        repeat (6) tick();
        chk("fl_occ", 32'(dut.occ_q), 32'd2);
        FLUSH   = 1'b1;
        M_READY = 1'b1;
        @(negedge FCLK);
        chk("fl_no_strobe", 32'(FIFO_RD_EN), 32'd0);
        tick();
        FLUSH   = 1'b0;
        M_READY = 1'b0;
        void'(exp_q.pop_front());
        chk("fl_pop_done", 32'(pops), 32'd1);
        chk("fl_valid", 32'(M_VALID), 32'd0);
        M_READY = 1'b1;
        wait_pops("fl_pops", 2, 20);
        wait_idle("fl_idle", 10);

        // Flush while a word is in flight
        M_READY = 1'b0;
        clear_stats();
        push_word(8'h51); push_word(8'h52);
        for (int k = 0; k < 10 && strobes < 2; k++) tick();
        chk("fl2_strobes", 32'(strobes), 32'd2);
        chk("fl2_busy", 32'(BUSY), 32'd1);
        FLUSH = 1'b1;
        @(negedge FCLK);
        chk("fl2_no_strobe", 32'(FIFO_RD_EN), 32'd0);
        tick();
        FLUSH = 1'b0;
        exp_q.delete();
        chk("fl2_valid", 32'(M_VALID), 32'd0);
        chk("fl2_drop_busy", 32'(BUSY), 32'd1);
        push_word(8'h77);
        M_READY = 1'b1;
        wait_pops("fl2_pops", 1, 20);
        wait_idle("fl2_idle", 10);

        // Random backpressure, 300 words
        FLUSH = 1'b1;
        tick();
        FLUSH = 1'b0;
`ifdef FIFO_DRAIN_READER_COUNT_EN
        chk("cnt_clr", 32'(RD_COUNT), 32'd0);
`endif
        clear_stats();
        for (int i = 0; i < 300; i++) begin
            push_word(8'(i * 7 + 3));
            M_READY = ($urandom_range(0, 3) != 0);
            tick();
        end
        M_READY = 1'b1;
        wait_pops("rand_pops", 300, 1000);
        wait_idle("rand_idle", 10);
        chk("rand_sb_empty", 32'(exp_q.size()), 32'd0);
`ifdef FIFO_DRAIN_READER_COUNT_EN
        chk("cnt_300", 32'(RD_COUNT), 32'd300);
        FLUSH = 1'b1;
        tick();
        FLUSH = 1'b0;
        chk("cnt_flush", 32'(RD_COUNT), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
